pic_bus_interface: RTL and testbench

//  Clocked, parametrised host-bus front end for the 8259A-style PIC: synchronises CS_n/WR_n/RD_n, runs the ICW1..ICW4 init FSM,

---
 rtl/pic_bus_interface_pkg.sv | 33 +++
 rtl/pic_bus_interface_if.sv | 15 +
 rtl/pic_bus_interface_strobe_sync.sv | 29 ++
 rtl/pic_bus_interface.sv | 176 +++++++++++++++++
 tb/tb_pic_bus_interface.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pic_bus_interface_pkg.sv
// Shared definitions for the PIC host-bus front end: FSM states, readback
// selectors and the A0=0 command decode.
package pic_bus_interface_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_W_ICW2 = 3'd1,
    ST_W_ICW3 = 3'd2,
    ST_W_ICW4 = 3'd3,
    ST_READY  = 3'd4
  } pic_state_t;

  localparam logic READ_IRR = 1'b0;
  localparam logic READ_ISR = 1'b1;

  typedef enum logic [1:0] {
    CMD_ICW1    = 2'd0,
    CMD_OCW2    = 2'd1,
    CMD_OCW3    = 2'd2,
    CMD_ILLEGAL = 2'd3
  } cmd_t;

  // Classifies an A0=0 byte from its D7, D4 and D3 bits.
  function automatic cmd_t decode_a0_low(input logic d7, input logic d4, input logic d3);
    cmd_t c;
    if (d4)       c = CMD_ICW1;
    else if (!d3) c = CMD_OCW2;
    else if (!d7) c = CMD_OCW3;
    else          c = CMD_ILLEGAL;
    return c;
  endfunction

endpackage

// File: rtl/pic_bus_interface_if.sv
// Host bus pins of the PIC: strobes, address, write data and the read bus.
// Handshake: a write is CS_n low then a WR_n low pulse; a read is CS_n low then an
// RD_n low pulse. D_out is valid whenever D_oe is high.
interface pic_bus_interface_if;
  logic       CS_n;
  logic       WR_n;
  logic       RD_n;
  logic       A0;
  logic [7:0] D_in;
  logic [7:0] D_out;
  logic       D_oe;

  modport master (output CS_n, WR_n, RD_n, A0, D_in, input D_out, D_oe);
  modport slave  (input CS_n, WR_n, RD_n, A0, D_in, output D_out, D_oe);
endinterface

// File: rtl/pic_bus_interface_strobe_sync.sv
// Multi-flop synchroniser for an active-low strobe with fall/rise pulse outputs.
module pic_bus_interface_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe_n,
  output logic sync_n,
  output logic fall,
  output logic rise
);
  logic [SYNC_STAGES-1:0] chain;
  logic                   prev_n;

  // Resetting to the idle (high) level means no edge can emerge from reset itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain  <= '1;
      prev_n <= 1'b1;
    end else begin
      chain  <= {chain[SYNC_STAGES-2:0], strobe_n};
      prev_n <= chain[SYNC_STAGES-1];
    end
  end

  assign sync_n = chain[SYNC_STAGES-1];
  assign fall   = prev_n & ~sync_n;
  assign rise   = ~prev_n & sync_n;
endmodule

// File: rtl/pic_bus_interface.sv
// Host-bus front end of the PIC: strobe synchronisation, ICW init FSM, OCW decode,
// mode/mask state and the readback bus.
module pic_bus_interface
  import pic_bus_interface_pkg::*;
#(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  pic_bus_interface_if.slave   bus,
  input  logic [N_IRQ-1:0]     IRR,
  input  logic [N_IRQ-1:0]     ISR,
  input  logic [2:0]           poll_level,
  input  logic                 poll_valid,
  input  logic [7:0]           inta_vec,
  input  logic                 inta_vec_valid,
  output logic [3:0]           icw_pulse,
  output logic [2:0]           ocw_pulse,
  output logic                 init_done,
  output logic                 single_mode,
  output logic                 ic4,
  output logic                 ltim,
  output logic [4:0]           vector_base,
  output logic [7:0]           cascade_cfg,
  output logic                 aeoi,
  output logic                 sfnm,
  output logic [N_IRQ-1:0]     IMR,
  output logic [2:0]           eoi_cmd,
  output logic [2:0]           eoi_level,
  output logic                 special_mask,
  output logic                 cmd_err,
  output pic_state_t           fsm_state
);
  logic wr_sync_n, wr_fall, wr_rise;
  logic rd_sync_n, rd_fall, rd_rise;
  logic [SYNC_STAGES-1:0] cs_chain;

  pic_bus_interface_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(clk), .rst(rst), .strobe_n(bus.WR_n), .sync_n(wr_sync_n), .fall(wr_fall), .rise(wr_rise));
  pic_bus_interface_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
    .clk(clk), .rst(rst), .strobe_n(bus.RD_n), .sync_n(rd_sync_n), .fall(rd_fall), .rise(rd_rise));

  always_ff @(posedge clk) begin
    if (rst) cs_chain <= '1;
    else     cs_chain <= {cs_chain[SYNC_STAGES-2:0], bus.CS_n};
  end

  pic_state_t state, state_d;
  logic       wr_active, rd_active, rd_poll, poll_pending, read_sel;
  logic [7:0] d_q, rd_data, rd_src, imr_byte, irr_byte, isr_byte;
  logic       a0_q, rd_a0_q;
  logic [3:0] icw_d;
  logic [2:0] ocw_d;
  logic       err_d;
  cmd_t       cmd;

  wire cs_low    = ~cs_chain[SYNC_STAGES-1];
  wire wr_start  = wr_fall & cs_low;
  wire rd_start  = rd_fall & cs_low;
  wire wr_accept = wr_start & ~rd_active;
  wire rd_accept = rd_start & ~rd_active & ~wr_active & ~wr_start;
  wire commit    = wr_rise & wr_active;

  always_comb begin
    state_d = state;
    icw_d   = '0;
    ocw_d   = '0;
    err_d   = wr_accept & rd_start;
    cmd     = decode_a0_low(d_q[7], d_q[4], d_q[3]);
    if (commit) begin
      if (!a0_q && cmd == CMD_ICW1) begin
        icw_d[0] = 1'b1;
        state_d  = ST_W_ICW2;
      end else begin
        unique case (state)
          ST_W_ICW2: if (a0_q) begin
            icw_d[1] = 1'b1;
            state_d  = !single_mode ? ST_W_ICW3 : (ic4 ? ST_W_ICW4 : ST_READY);
          end else err_d = 1'b1;
          ST_W_ICW3: if (a0_q) begin
            icw_d[2] = 1'b1;
            state_d  = ic4 ? ST_W_ICW4 : ST_READY;
          end else err_d = 1'b1;
          ST_W_ICW4: if (a0_q) begin
            icw_d[3] = 1'b1;
            state_d  = ST_READY;
          end else err_d = 1'b1;
          ST_READY: begin
            if (a0_q)                  ocw_d[0] = 1'b1;
            else if (cmd == CMD_OCW2)  ocw_d[1] = 1'b1;
            else if (cmd == CMD_OCW3)  ocw_d[2] = 1'b1;
            else                       err_d    = 1'b1;
          end
          default: err_d = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    imr_byte = '0;
    irr_byte = '0;
    isr_byte = '0;
    imr_byte[N_IRQ-1:0] = IMR;
    irr_byte[N_IRQ-1:0] = IRR;
    isr_byte[N_IRQ-1:0] = ISR;
    if (rd_a0_q)                   rd_src = imr_byte;
    else if (poll_pending)         rd_src = {poll_valid, 4'b0000, poll_level};
    else if (read_sel == READ_ISR) rd_src = isr_byte;
    else                           rd_src = irr_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      {wr_active, rd_active, rd_poll, poll_pending, read_sel} <= '0;
      {d_q, a0_q, rd_a0_q, rd_data} <= '0;
      {icw_pulse, ocw_pulse, cmd_err, init_done} <= '0;
      {single_mode, ic4, ltim, vector_base, cascade_cfg, aeoi, sfnm} <= '0;
      {IMR, eoi_cmd, eoi_level, special_mask} <= '0;
    end else begin
      state     <= state_d;
      icw_pulse <= icw_d;
      ocw_pulse <= ocw_d;
      cmd_err   <= err_d;
      if (!wr_sync_n) begin
        d_q  <= bus.D_in;
        a0_q <= bus.A0;
      end
      // Read address is taken from before the synced RD_n fall, when A0 is settled.
      if (rd_sync_n) rd_a0_q <= bus.A0;
      if (wr_accept)   wr_active <= 1'b1;
      else if (wr_rise) wr_active <= 1'b0;
      if (rd_accept) begin
        rd_active <= 1'b1;
        rd_data   <= rd_src;
        rd_poll   <= ~rd_a0_q & poll_pending;
      end else if (rd_rise && rd_active) begin
        rd_active <= 1'b0;
        if (rd_poll) poll_pending <= 1'b0;
      end
      if (icw_d[0]) begin
        ltim         <= d_q[3];
        single_mode  <= d_q[1];
        ic4          <= d_q[0];
        IMR          <= '0;
        special_mask <= 1'b0;
        poll_pending <= 1'b0;
        init_done    <= 1'b0;
        read_sel     <= READ_IRR;
      end
      if (icw_d[1]) vector_base <= d_q[7:3];
      if (icw_d[2]) cascade_cfg <= d_q;
      if (icw_d[3]) begin
        aeoi <= ic4 & d_q[1];
        sfnm <= ic4 & d_q[4];
      end
      if (state_d == ST_READY && state != ST_READY) init_done <= 1'b1;
      if (ocw_d[0]) IMR <= d_q[N_IRQ-1:0];
      if (ocw_d[1]) begin
        eoi_cmd   <= d_q[7:5];
        eoi_level <= d_q[2:0];
      end
      if (ocw_d[2]) begin
        if (d_q[1]) read_sel     <= d_q[0];
        if (d_q[6]) special_mask <= d_q[5];
        if (d_q[2]) poll_pending <= 1'b1;
      end
    end
  end

  assign bus.D_out = inta_vec_valid ? inta_vec : rd_data;
  assign bus.D_oe  = inta_vec_valid | rd_active;
  assign fsm_state = state;
endmodule

// File: tb/tb_pic_bus_interface.sv
// Scoreboard bench for pic_bus_interface: a behavioural model predicts each write
// event and read byte; a monitor compares them when the DUT presents them.
module tb_pic_bus_interface;
  import pic_bus_interface_pkg::*;

  localparam int W = 42;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pic_bus_interface_if bus();
  logic [7:0] IRR, ISR, inta_vec;
  logic [2:0] poll_level;
  logic       poll_valid, inta_vec_valid;
  logic [3:0] icw_pulse;
  logic [2:0] ocw_pulse, eoi_cmd, eoi_level;
  logic       init_done, single_mode, ic4, ltim, aeoi, sfnm, special_mask, cmd_err;
  logic [4:0] vector_base;
  logic [7:0] cascade_cfg, IMR;
  pic_state_t fsm_state;

  pic_bus_interface dut (
    .clk(clk), .rst(rst), .bus(bus), .IRR(IRR), .ISR(ISR),
    .poll_level(poll_level), .poll_valid(poll_valid),
    .inta_vec(inta_vec), .inta_vec_valid(inta_vec_valid),
    .icw_pulse(icw_pulse), .ocw_pulse(ocw_pulse), .init_done(init_done),
    .single_mode(single_mode), .ic4(ic4), .ltim(ltim), .vector_base(vector_base),
    .cascade_cfg(cascade_cfg), .aeoi(aeoi), .sfnm(sfnm), .IMR(IMR),
    .eoi_cmd(eoi_cmd), .eoi_level(eoi_level), .special_mask(special_mask),
    .cmd_err(cmd_err), .fsm_state(fsm_state)
  );

  wire [W-1:0] obs = {icw_pulse, ocw_pulse, cmd_err, init_done, single_mode, ic4, ltim,
                      vector_base, cascade_cfg, aeoi, sfnm, IMR, special_mask, eoi_cmd, eoi_level};

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   rd_q[$];

  // Reference model; m_next is the ICW number awaited next (0 = not started, 5 = initialised).
  int         m_next;
  bit         m_ltim, m_single, m_ic4, m_aeoi, m_sfnm, m_smm, m_poll, m_init, m_sel;
  logic [4:0] m_vb;
  logic [7:0] m_cas, m_imr;
  logic [2:0] m_ecmd, m_elvl;

  task automatic model_reset();
    m_next = 0;
    {m_ltim, m_single, m_ic4, m_aeoi, m_sfnm, m_smm, m_poll, m_init, m_sel} = '0;
    m_vb = 0; m_cas = 0; m_imr = 0; m_ecmd = 0; m_elvl = 0;
  endtask

  function automatic logic [W-1:0] snap(input logic [3:0] icw, input logic [2:0] ocw, input logic err);
    return {icw, ocw, err, m_init, m_single, m_ic4, m_ltim, m_vb, m_cas, m_aeoi, m_sfnm,
            m_imr, m_smm, m_ecmd, m_elvl};
  endfunction

  task automatic model_write(input logic a0, input logic [7:0] d);
    logic [3:0] icw = 0;
    logic [2:0] ocw = 0;
    logic       err = 0;
    if (!a0 && d[4]) begin
      m_ltim = d[3]; m_single = d[1]; m_ic4 = d[0];
      m_imr = 0; m_smm = 0; m_poll = 0; m_init = 0; m_sel = 0;
      m_next = 2; icw = 4'b0001;
    end else if (m_next >= 2 && m_next <= 4 && a0) begin
      if (m_next == 2) begin
        m_vb = d[7:3]; icw = 4'b0010;
        m_next = !m_single ? 3 : (m_ic4 ? 4 : 5);
      end else if (m_next == 3) begin
        m_cas = d; icw = 4'b0100;
        m_next = m_ic4 ? 4 : 5;
      end else begin
        m_aeoi = m_ic4 & d[1]; m_sfnm = m_ic4 & d[4]; icw = 4'b1000;
        m_next = 5;
      end
      if (m_next == 5) m_init = 1;
    end else if (m_next == 5) begin
      if (a0) begin
        m_imr = d; ocw = 3'b001;
      end else if (!d[3]) begin
        m_ecmd = d[7:5]; m_elvl = d[2:0]; ocw = 3'b010;
      end else if (!d[7]) begin
        if (d[1]) m_sel = d[0];
        if (d[6]) m_smm = d[5];
        if (d[2]) m_poll = 1;
        ocw = 3'b100;
      end else err = 1;
    end else err = 1;
    exp_q.push_back(snap(icw, ocw, err));
  endtask

  task automatic model_read(input logic a0);
    logic [7:0] v;
    if (a0)          v = m_imr;
    else if (m_poll) v = {poll_valid, 4'b0000, poll_level};
    else if (m_sel)  v = ISR;
    else             v = IRR;
    if (!a0) m_poll = 0;
    rd_q.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic a0, input logic [7:0] d, input bit use_cs);
    if (use_cs) model_write(a0, d);
    bus.A0 = a0; bus.D_in = d; bus.CS_n = !use_cs;
    tick(1); bus.WR_n = 1'b0;
    tick(4); bus.WR_n = 1'b1;
    tick(4); bus.CS_n = 1'b1;
    tick(2);
  endtask

  task automatic bus_read(input logic a0);
    int k;
    model_read(a0);
    bus.A0 = a0; bus.CS_n = 1'b0;
    tick(1); bus.RD_n = 1'b0;
    k = 0;
    while (!bus.D_oe && k < 8) begin tick(1); k++; end
    check("rd_oe_rise", bus.D_oe, 1);
    tick(2); bus.RD_n = 1'b1;
    k = 0;
    while (bus.D_oe && k < 4) begin tick(1); k++; end
    check("rd_oe_fall", bus.D_oe, 0);
    bus.CS_n = 1'b1;
    tick(2);
  endtask

  // Write and read strobes together (lag 0) or read starting after the write (lag > 0).
  task automatic collide(input logic a0, input logic [7:0] d, input int lag);
    if (lag == 0) exp_q.push_back(snap(4'b0, 3'b0, 1'b1));
    model_write(a0, d);
    bus.A0 = a0; bus.D_in = d; bus.CS_n = 1'b0;
    tick(1); bus.WR_n = 1'b0;
    if (lag == 0) bus.RD_n = 1'b0;
    else begin tick(lag); bus.RD_n = 1'b0; end
    tick(4); bus.WR_n = 1'b1;
    tick(4); bus.RD_n = 1'b1;
    tick(4); bus.CS_n = 1'b1;
    tick(2);
  endtask

  task automatic write_during_read(input logic a0);
    model_read(a0);
    bus.A0 = a0; bus.D_in = 8'h13; bus.CS_n = 1'b0;
    tick(1); bus.RD_n = 1'b0;
    tick(5); bus.WR_n = 1'b0;
    tick(3); bus.WR_n = 1'b1;
    tick(3); bus.RD_n = 1'b1;
    tick(5); bus.CS_n = 1'b1;
    tick(2);
  endtask

  logic prev_oe = 1'b0;
  always @(negedge clk) begin
    if (!inta_vec_valid) begin
      if (bus.D_oe) begin
        if (rd_q.size() == 0) check("rd_unexpected", bus.D_out, 8'hxx);
        else check("rd_data", bus.D_out, rd_q[0]);
      end else if (prev_oe && rd_q.size() > 0) begin
        void'(rd_q.pop_front());
      end
      prev_oe = bus.D_oe;
    end
    if (!rst && (icw_pulse != 0 || ocw_pulse != 0 || cmd_err)) begin
      if (exp_q.size() == 0) check("wr_unexpected", obs, '0);
      else check("wr_event", obs, exp_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic       a0;
    logic [7:0] d;
    rst = 1'b1;
    bus.CS_n = 1'b1; bus.WR_n = 1'b1; bus.RD_n = 1'b1; bus.A0 = 1'b0; bus.D_in = 8'h00;
    IRR = 8'h00; ISR = 8'h00; poll_level = 3'd0; poll_valid = 1'b0;
    inta_vec = 8'h00; inta_vec_valid = 1'b0;
    model_reset();
    tick(5); rst = 1'b0; tick(1);

    check("reset_regs", obs, '0);
    check("reset_dout", bus.D_out, 0);
    check("reset_doe", bus.D_oe, 0);
    check("reset_state", fsm_state, ST_IDLE);

    bus_write(0, 8'h20, 1);                 // OCW2 before init
    bus_write(0, 8'h13, 1); bus_write(1, 8'h48, 1); bus_write(1, 8'h03, 1);
    check("ready_state", fsm_state, ST_READY);
    bus_write(0, 8'h11, 1); bus_write(1, 8'h20, 1); bus_write(1, 8'h04, 1); bus_write(1, 8'h01, 1);

    bus_write(1, 8'hA5, 1);
    bus_read(1);
    ISR = 8'h10; IRR = 8'h6C;
    bus_write(0, 8'h0B, 1); bus_read(0);
    bus_write(0, 8'h0A, 1); bus_read(0);
    poll_valid = 1'b1; poll_level = 3'd5;
    bus_write(0, 8'h0C, 1); bus_read(0); bus_read(0);
    bus_write(0, 8'h67, 1);                 // OCW2 with eoi fields
    bus_write(0, 8'h68, 1);                 // special mask on

    bus_write(1, 8'hFF, 0);                 // no chip select
    bus_write(0, 8'h88, 1);                 // illegal A0=0 byte
    collide(1, 8'h3C, 0);
    collide(1, 8'hC3, 2);
    write_during_read(1);

    inta_vec = 8'h5A; inta_vec_valid = 1'b1;
    tick(1);
    check("inta_dout", bus.D_out, 8'h5A);
    check("inta_doe", bus.D_oe, 1);
    inta_vec_valid = 1'b0; tick(1);

    bus_write(0, 8'h1B, 1);                 // ICW1 while READY
    check("reinit_state", fsm_state, ST_W_ICW2);

    model_read(1);                          // reset during an active read
    bus.A0 = 1'b1; bus.CS_n = 1'b0; tick(1); bus.RD_n = 1'b0;
    tick(5);
    rst = 1'b1; tick(1);
    check("rst_doe", bus.D_oe, 0);
    bus.RD_n = 1'b1; bus.CS_n = 1'b1;
    tick(4); rst = 1'b0; model_reset(); tick(1);
    check("rst_regs", obs, '0);
    check("rst_state", fsm_state, ST_IDLE);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        IRR = 8'($urandom); ISR = 8'($urandom);
        poll_level = 3'($urandom_range(0, 7)); poll_valid = 1'($urandom_range(0, 1));
        bus_read(1'($urandom_range(0, 1)));
      end else begin
        a0 = 1'($urandom_range(0, 1));
        d  = 8'($urandom);
        if ($urandom_range(0, 9) == 0) begin a0 = 1'b0; d[4] = 1'b1; end
        if (m_next >= 2 && m_next <= 4 && $urandom_range(0, 1) == 1) a0 = 1'b1;
        bus_write(a0, d, 1);
      end
    end

    tick(10);
    check("exp_q_drained", exp_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
